// File: rtl/mdu_types_pkg.sv
// mdu_types_pkg: operation codes, FSM states and op-decode helpers for the multiply/divide unit
package mdu_types_pkg;
  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_op_t;
  typedef enum logic [2:0] {IDLE, PREP, BUSY, POST, DONE} mdu_state_t;
  function automatic logic is_div(input mdu_op_t op);
    return op[2];
  endfunction
  function automatic logic is_rem(input mdu_op_t op);
    return op[2] & op[1];
  endfunction
  function automatic logic is_signed_a(input mdu_op_t op);
    return op == MDU_MULH || op == MDU_MULHSU || op == MDU_DIV || op == MDU_REM;
  endfunction
  function automatic logic is_signed_b(input mdu_op_t op);
    return op == MDU_MULH || op == MDU_DIV || op == MDU_REM;
  endfunction
endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one shift-add multiply or restoring divide iteration on the shared hi/lo pair
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
  assign sh   = {hi, lo[WIDTH-1]};
  assign diff = {1'b0, sh} - {2'b0, b};
  // A clear top bit of diff means no borrow: keep the difference and emit quotient bit 1
  assign hi_n = div ? (diff[WIDTH+1] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
  assign lo_n = div ? {lo[WIDTH-2:0], ~diff[WIDTH+1]} : {sum[0], lo[WIDTH-1:1]};
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle RV32M/RV64M multiply/divide unit, one bit per cycle
module mdu_iterative
  import mdu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  mdu_op_t          req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0] resp_tag
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  mdu_state_t         state;
  mdu_op_t            op;
  logic [TAG_W-1:0]   tag;
  logic [WIDTH-1:0]   a, b, hi, lo, hi_n, lo_n, a_abs, b_abs, special_val, post_val;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;
  logic               sa, sb, sa_c, sb_c, dz, ovf, special;
  assign req_ready = state == IDLE;
  always_comb begin
    sa_c        = is_signed_a(op) & a[WIDTH-1];
    sb_c        = is_signed_b(op) & b[WIDTH-1];
    a_abs       = sa_c ? -a : a;
    b_abs       = sb_c ? -b : b;
    dz          = b == '0;
    ovf         = (op == MDU_DIV || op == MDU_REM) && a == MIN && b == '1;
    special     = is_div(op) && (dz || ovf);
    special_val = dz ? (is_rem(op) ? a : '1) : (is_rem(op) ? '0 : MIN);
    prod        = (sa ^ sb) ? -{hi, lo} : {hi, lo};
    post_val    = is_div(op) ? (is_rem(op) ? (sa ? -hi : hi) : ((sa ^ sb) ? -lo : lo))
                             : (op == MDU_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  end
  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .div (is_div(op)),
    .hi  (hi),
    .lo  (lo),
    .b   (b),
    .hi_n(hi_n),
    .lo_n(lo_n)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op    <= req_op;
          a     <= req_a;
          b     <= req_b;
          tag   <= req_tag;
          state <= PREP;
        end
        PREP: if (special) begin
          resp_data  <= special_val;
          resp_tag   <= tag;
          resp_valid <= 1'b1;
          state      <= DONE;
        end else begin
          hi    <= '0;
          lo    <= a_abs;
          b     <= b_abs;
          sa    <= sa_c;
          sb    <= sb_c;
          count <= CW'(WIDTH - 1);
          state <= BUSY;
        end
        BUSY: begin
          hi    <= hi_n;
          lo    <= lo_n;
          count <= count - 1'b1;
          if (count == '0) state <= POST;
        end
        POST: begin
          resp_data  <= post_val;
          resp_tag   <= tag;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed vectors for 32- and 64-bit instances of mdu_iterative
module tb_mdu_iterative;
  import mdu_types_pkg::*;
  logic        CLK = 1'b0, RST = 1'b1, flush = 1'b0, resp_ready = 1'b0, v32 = 1'b0, v64 = 1'b0;
  mdu_op_t     req_op = MDU_MUL;
  logic [63:0] req_a = '0, req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        rdy32, rdy64, rv32, rv64;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [4:0]  t32, t64;
  int          n_cmp = 0, n_bad = 0;
  always #5 CLK = ~CLK;
  mdu_iterative #(.WIDTH(32), .TAG_W(5)) dut32 (
    .CLK(CLK), .RST(RST), .req_valid(v32), .req_ready(rdy32), .req_op(req_op),
    .req_a(req_a[31:0]), .req_b(req_b[31:0]), .req_tag(req_tag), .flush(flush),
    .resp_valid(rv32), .resp_ready(resp_ready), .resp_data(d32), .resp_tag(t32)
  );
  mdu_iterative #(.WIDTH(64), .TAG_W(5)) dut64 (
    .CLK(CLK), .RST(RST), .req_valid(v64), .req_ready(rdy64), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .resp_valid(rv64), .resp_ready(resp_ready), .resp_data(d64), .resp_tag(t64)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic issue(input bit w, input mdu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] t);
    req_op = op; req_a = a; req_b = b; req_tag = t; v32 = !w; v64 = w;
    tick();
    v32 = 1'b0; v64 = 1'b0;
  endtask
  task automatic run(input string nm, input bit w, input mdu_op_t op, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] t, input logic [63:0] exp, input int lat);
    int n;
    issue(w, op, a, b, t);
    n = 1;
    while (!(w ? rv64 : rv32) && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_data"}, w ? d64 : {32'b0, d32}, exp);
    chk({nm, "_tag"}, 64'(w ? t64 : t32), 64'(t));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({nm, "_drop"}, 64'(w ? rv64 : rv32), 64'd0);
  endtask
  initial begin
    int seen, n;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_valid", 64'(rv32), 64'd0);
    chk("rst_data", 64'(d32), 64'd0);
    chk("rst_tag", 64'(t32), 64'd0);
    run("mul", 0, MDU_MUL, 64'd7, 64'hFFFF_FFFD, 5'h01, 64'hFFFF_FFEB, 35);
    run("mulh", 0, MDU_MULH, 64'd7, 64'hFFFF_FFFD, 5'h02, 64'hFFFF_FFFF, 35);
    run("mulhu", 0, MDU_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'h03, 64'hFFFF_FFFE, 35);
    run("mulhsu", 0, MDU_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'h04, 64'hFFFF_FFFF, 35);
    run("mulh_min", 0, MDU_MULH, 64'h8000_0000, 64'h8000_0000, 5'h05, 64'h4000_0000, 35);
    run("div", 0, MDU_DIV, 64'hFFFF_FFEC, 64'd6, 5'h06, 64'hFFFF_FFFD, 35);
    run("rem", 0, MDU_REM, 64'hFFFF_FFEC, 64'd6, 5'h07, 64'hFFFF_FFFE, 35);
    run("divu", 0, MDU_DIVU, 64'd20, 64'd6, 5'h08, 64'd3, 35);
    run("remu", 0, MDU_REMU, 64'd20, 64'd6, 5'h09, 64'd2, 35);
    run("div0", 0, MDU_DIV, 64'h1234, 64'd0, 5'h0A, 64'hFFFF_FFFF, 2);
    run("rem0", 0, MDU_REM, 64'h1234, 64'd0, 5'h0B, 64'h1234, 2);
    run("divu0", 0, MDU_DIVU, 64'h1234, 64'd0, 5'h0C, 64'hFFFF_FFFF, 2);
    run("div_ovf", 0, MDU_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 5'h0D, 64'h8000_0000, 2);
    run("rem_ovf", 0, MDU_REM, 64'h8000_0000, 64'hFFFF_FFFF, 5'h0E, 64'd0, 2);
    // backpressure: result must sit untouched while the consumer stalls
    issue(0, MDU_MUL, 64'd3, 64'd5, 5'h09);
    n = 1;
    while (!rv32 && n < 200) begin
      tick();
      n++;
    end
    chk("bp_lat", 64'(n), 64'd35);
    repeat (10) begin
      tick();
      chk("bp_data", 64'(d32), 64'd15);
      chk("bp_tag", 64'(t32), 64'h09);
      chk("bp_ready", 64'(rdy32), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_idle_ready", 64'(rdy32), 64'd1);
    chk("bp_idle_valid", 64'(rv32), 64'd0);
    run("bp_next", 0, MDU_DIVU, 64'd100, 64'd7, 5'h10, 64'd14, 35);
    // flush during the fifth BUSY cycle, then a flush colliding with a new request
    issue(0, MDU_DIVU, 64'd1000, 64'd7, 5'h15);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_ready", 64'(rdy32), 64'd1);
    chk("flush_busy_valid", 64'(rv32), 64'd0);
    req_op = MDU_MUL; req_a = 64'd2; req_b = 64'd2; req_tag = 5'h16; v32 = 1'b1; flush = 1'b1;
    tick();
    v32 = 1'b0; flush = 1'b0;
    chk("flush_wins_ready", 64'(rdy32), 64'd1);
    seen = 0;
    repeat (50) begin
      tick();
      if (rv32) seen = 1;
    end
    chk("flush_no_resp", 64'(seen), 64'd0);
    // flush together with resp_ready while a result waits
    issue(0, MDU_REM, 64'h1234, 64'd0, 5'h17);
    tick();
    chk("flush_done_valid_pre", 64'(rv32), 64'd1);
    flush = 1'b1; resp_ready = 1'b1;
    tick();
    flush = 1'b0; resp_ready = 1'b0;
    chk("flush_done_valid", 64'(rv32), 64'd0);
    chk("flush_done_ready", 64'(rdy32), 64'd1);
    // reset while busy clears every output
    issue(0, MDU_MUL, 64'd7, 64'd9, 5'h03);
    repeat (10) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_busy_valid", 64'(rv32), 64'd0);
    chk("rst_busy_data", 64'(d32), 64'd0);
    chk("rst_busy_tag", 64'(t32), 64'd0);
    chk("rst_busy_ready", 64'(rdy32), 64'd1);
    chk("rst64_ready", 64'(rdy64), 64'd1);
    run("mulhu64", 1, MDU_MULHU, 64'h1_0000_0000, 64'h1_0000_0000, 5'h04, 64'd1, 67);
    run("mul64", 1, MDU_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 5'h05, 64'd0, 67);
    run("div64", 1, MDU_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'h06, 64'hFFFF_FFFF_FFFF_FFFD, 67);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
